// File: rtl/conv_layer_calc_pkg.sv
// Shared constants and helpers for the convolution dot-product block:
// kernel-size to accumulator-extension mapping and result-width helper.
package conv_layer_calc_pkg;

   localparam int DEF_KERNEL = 7;
   localparam int DEF_N      = 4;
   localparam int DEF_M      = 4;

   // Extension bits that make a KERNEL*KERNEL-term sum overflow-free;
   // -1 marks an unsupported kernel size.
   function automatic int kernel_ext(input int kernel);
      case (kernel)
         1:       return 0;
         3:       return 3;
         5:       return 5;
         7:       return 6;
         default: return -1;
      endcase
   endfunction

   function automatic bit kernel_legal(input int kernel);
      return kernel_ext(kernel) >= 0;
   endfunction

   // Width of the signed dot-product result.
   function automatic int result_width(input int n, input int m, input int e);
      return n + m + e;
   endfunction

endpackage

// File: rtl/conv_layer_calc_if.sv
// Window/weight input bus and result output bus of conv_layer_calc.
interface conv_layer_calc_if #(
   parameter int KERNEL = 7,
   parameter int N      = 4,
   parameter int M      = 4,
   parameter int E      = 6
);
   import conv_layer_calc_pkg::*;

   localparam int T  = KERNEL * KERNEL;
   localparam int RW = result_width(N, M, E);

   logic [T*N-1:0] data2conv;
   logic           en_in;
   logic [T*M-1:0] w;
   logic [RW-1:0]  d_out;
   logic           en_out;

   modport master (output data2conv, en_in, w, input d_out, en_out);
   modport slave  (input data2conv, en_in, w, output d_out, en_out);

endinterface

// File: rtl/conv_layer_calc_carry_save_adder.sv
// Sums T signed W-bit terms into a W+E bit result using a chain of 3:2
// compressors followed by one carry-propagate add; wraps modulo 2^(W+E).
module carry_save_adder #(
   parameter int T = 9,
   parameter int E = 3,
   parameter int W = 8
) (
   input  logic [T*W-1:0] terms,
   output logic [W+E-1:0] sum
);
   localparam int RW = W + E;

   logic [RW-1:0] ext [T];

   // Sign-extend every term to the result width before compression.
   generate
      for (genvar gi = 0; gi < T; gi++) begin : g_ext
         assign ext[gi] = RW'($signed(terms[gi*W +: W]));
      end
   endgenerate

   // Carry-save reduction: keep a redundant (sum, carry) pair, fold one term per step.
   always_comb begin
      logic [RW-1:0] s_acc;
      logic [RW-1:0] c_acc;
      logic [RW-1:0] c_new;
      s_acc = ext[0];
      c_acc = '0;
      c_new = '0;
      for (int i = 1; i < T; i++) begin
         c_new = ((s_acc & c_acc) | (s_acc & ext[i]) | (c_acc & ext[i])) << 1;
         s_acc = s_acc ^ c_acc ^ ext[i];
         c_acc = c_new;
      end
      sum = s_acc + c_acc;
   end

endmodule

// File: rtl/conv_layer_calc.sv
// Two-stage pipelined signed dot product of a KERNEL x KERNEL window with
// its weights: stage 1 registers the products, stage 2 registers the sum.
module conv_layer_calc
   import conv_layer_calc_pkg::*;
#(
   parameter int KERNEL = DEF_KERNEL,
   parameter int E      = 6,
   parameter int N      = DEF_N,
   parameter int M      = DEF_M
) (
   input logic               clk,
   input logic               rst,
   conv_layer_calc_if.slave  bus
);
   localparam int T  = KERNEL * KERNEL;
   localparam int W  = N + M;
   localparam int RW = result_width(N, M, E);

   generate
      if (!kernel_legal(KERNEL)) begin : g_bad_kernel
         $error("conv_layer_calc: KERNEL must be 1, 3, 5 or 7");
      end
   endgenerate

   logic [T*W-1:0] prod_flat;
   logic [RW-1:0]  sum_comb;
   logic [RW-1:0]  sum_reg;
   logic           valid1;
   logic           valid2;

   generate
      for (genvar gi = 0; gi < T; gi++) begin : g_mul
         logic signed [W-1:0] d_ext;
         logic signed [W-1:0] w_ext;
         logic signed [W-1:0] prod_reg;

         assign d_ext = W'($signed(bus.data2conv[gi*N +: N]));
         assign w_ext = W'($signed(bus.w[gi*M +: M]));

         // Stage 1: capture this tap's product only on a valid input cycle.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               prod_reg <= '0;
            else if (bus.en_in)
               prod_reg <= d_ext * w_ext;
         end

         assign prod_flat[gi*W +: W] = prod_reg;
      end
   endgenerate

   carry_save_adder #(
      .T (T),
      .E (E),
      .W (W)
   ) u_csa (
      .terms (prod_flat),
      .sum   (sum_comb)
   );

   // Valid pipeline: en_in delayed by two edges, flushed by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid1 <= 1'b0;
         valid2 <= 1'b0;
      end else begin
         valid1 <= bus.en_in;
         valid2 <= valid1;
      end
   end

   // Stage 2: register the sum only when stage 1 holds fresh products.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sum_reg <= '0;
      else if (valid1)
         sum_reg <= sum_comb;
   end

   assign bus.d_out  = sum_reg;
   assign bus.en_out = valid2;

endmodule

// File: tb/tb_conv_layer_calc.sv
// Directed test of conv_layer_calc: KERNEL=3 (11-bit result) and KERNEL=1
// (8-bit result) instances, with hand-computed expected values.
module tb_conv_layer_calc;

   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   conv_layer_calc_if #(.KERNEL(3), .N(4), .M(4), .E(3)) bus3 ();
   conv_layer_calc_if #(.KERNEL(1), .N(4), .M(4), .E(0)) bus1 ();

   conv_layer_calc #(.KERNEL(3), .E(3), .N(4), .M(4)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   conv_layer_calc #(.KERNEL(1), .E(0), .N(4), .M(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int dv [9] = '{-4, -3, -2, -1, 0, 1, 2, 3, 4};
   int wv [9] = '{1, 2, 3, 4, 5, 6, 7, -8, -1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set3(input int d, input int wt);
      for (int k = 0; k < 9; k++) begin
         bus3.data2conv[k*4 +: 4] = 4'(d);
         bus3.w[k*4 +: 4]         = 4'(wt);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus3.en_in = 1'b0; bus3.data2conv = '0; bus3.w = '0;
      bus1.en_in = 1'b0; bus1.data2conv = '0; bus1.w = '0;
      #1 rst = 1'b0;
      #1;
      check("rst_d_out",    32'(bus3.d_out),  32'h0);
      check("rst_en_out",   32'(bus3.en_out), 32'h0);
      check("rst_k1_d_out", 32'(bus1.d_out),  32'h0);
      @(negedge clk);
      rst = 1'b1;

      // All ones: sum 9, latency exactly two edges, single pulse, hold.
      tick();
      set3(1, 1); bus3.en_in = 1'b1;
      tick();
      bus3.en_in = 1'b0;
      check("ones_lat1_en", 32'(bus3.en_out), 32'h0);
      tick();
      check("ones_en",   32'(bus3.en_out), 32'h1);
      check("ones_d",    32'(bus3.d_out),  32'h009);
      tick();
      check("ones_en_off", 32'(bus3.en_out), 32'h0);
      check("ones_hold",   32'(bus3.d_out),  32'h009);

      // Most negative times most negative: 64*9 = 576.
      set3(-8, -8); bus3.en_in = 1'b1;
      tick();
      bus3.en_in = 1'b0;
      tick();
      check("neg_en", 32'(bus3.en_out), 32'h1);
      check("neg_d",  32'(bus3.d_out),  32'h240);
      tick();
      check("neg_en_off", 32'(bus3.en_out), 32'h0);

      // 7 * -8 * 9 = -504.
      set3(7, -8); bus3.en_in = 1'b1;
      tick();
      bus3.en_in = 1'b0;
      tick();
      check("mix_en", 32'(bus3.en_out), 32'h1);
      check("mix_d",  32'(bus3.d_out),  32'h608);
      tick();

      // Distinct per-tap values: sum = -28.
      for (int k = 0; k < 9; k++) begin
         bus3.data2conv[k*4 +: 4] = 4'(dv[k]);
         bus3.w[k*4 +: 4]         = 4'(wv[k]);
      end
      bus3.en_in = 1'b1;
      tick();
      bus3.en_in = 1'b0;
      tick();
      check("taps_en", 32'(bus3.en_out), 32'h1);
      check("taps_d",  32'(bus3.d_out),  32'h7E4);
      tick();

      // Back-to-back: 9, 576, -504 on consecutive cycles.
      set3(1, 1); bus3.en_in = 1'b1;
      tick();
      check("b2b_pre_en", 32'(bus3.en_out), 32'h0);
      set3(-8, -8);
      tick();
      check("b2b_en0", 32'(bus3.en_out), 32'h1);
      check("b2b_d0",  32'(bus3.d_out),  32'h009);
      set3(7, -8);
      tick();
      bus3.en_in = 1'b0;
      check("b2b_en1", 32'(bus3.en_out), 32'h1);
      check("b2b_d1",  32'(bus3.d_out),  32'h240);
      tick();
      check("b2b_en2", 32'(bus3.en_out), 32'h1);
      check("b2b_d2",  32'(bus3.d_out),  32'h608);
      tick();
      check("b2b_en_off", 32'(bus3.en_out), 32'h0);
      check("b2b_hold",   32'(bus3.d_out),  32'h608);
      tick();
      check("b2b_hold2",  32'(bus3.d_out),  32'h608);

      // Reset mid-stream with data in flight.
      set3(1, 1); bus3.en_in = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1;
      check("mrst_d_now",  32'(bus3.d_out),  32'h0);
      check("mrst_en_now", 32'(bus3.en_out), 32'h0);
      tick();
      check("mrst_d_held",  32'(bus3.d_out),  32'h0);
      check("mrst_en_held", 32'(bus3.en_out), 32'h0);
      bus3.en_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mrst_no_stale", 32'(bus3.en_out), 32'h0);
      end

      // First transaction after reset release: 2*1*9 = 18.
      set3(2, 1); bus3.en_in = 1'b1;
      tick();
      bus3.en_in = 1'b0;
      check("post_rst_lat1", 32'(bus3.en_out), 32'h0);
      tick();
      check("post_rst_en", 32'(bus3.en_out), 32'h1);
      check("post_rst_d",  32'(bus3.d_out),  32'h012);

      // KERNEL=1: -3 * 5 = -15.
      bus1.data2conv = 4'hD; bus1.w = 4'h5; bus1.en_in = 1'b1;
      tick();
      bus1.en_in = 1'b0;
      check("k1_lat1_en", 32'(bus1.en_out), 32'h0);
      tick();
      check("k1_en", 32'(bus1.en_out), 32'h1);
      check("k1_d",  32'(bus1.d_out),  32'h0F1);
      tick();
      check("k1_en_off", 32'(bus1.en_out), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_layer_calc.md
CONV_LAYER_CALC -- requirements
Module: conv_layer_calc

Interface
REQ-001 Parameter KERNEL, default 7: kernel side length; legal values 1, 3, 5, 7; taps T = KERNEL*KERNEL.
REQ-002 Parameter E, default 6: accumulator extension bits; callers pass 0/3/5/6 for KERNEL 1/3/5/7.
REQ-003 Parameter N, default 4: data element width in bits.
REQ-004 Parameter M, default 4: weight element width in bits.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 data2conv  input  T*N  window data; tap k at bits [k*N +: N].
REQ-008 en_in  input  1  input-valid strobe for data2conv/w this cycle.
REQ-009 w  input  T*M  kernel weights; tap k at bits [k*M +: M], paired with data tap k.
REQ-010 d_out  output  N+M+E  dot-product result, registered.
REQ-011 en_out  output  1  result-valid strobe aligned with d_out.

Function
REQ-012 Data and weight elements are signed two's complement; d_out is signed two's complement of width N+M+E.
REQ-013 d_out = sum over k=0..T-1 of data_k * w_k, each product sign-extended to N+M+E before summation.
REQ-014 Width rule: each product is N+M bits; for the E values in REQ-002, the sum cannot overflow; for any other E, the result wraps modulo 2^(N+M+E), with no saturation.
REQ-015 KERNEL=1, E=0: d_out = data_0*w_0, width N+M.
REQ-016 Pipeline latency is exactly 2 cycles: stage 1 registers all T products, and stage 2 registers the sum.
REQ-017 en_out equals en_in delayed by exactly 2 clock edges; one en_out pulse per en_in pulse; back-to-back en_in cycles give back-to-back en_out cycles with no bubbles.
REQ-018 Stage registers load only when that stage's valid bit is 1, and otherwise hold their value; d_out therefore holds the last valid result while en_out=0.
REQ-019 No handshake or backpressure: the block accepts input every cycle.

Reset
REQ-020 While rst=0, all product registers, sum register, d_out and both valid stages clear to 0 immediately, independent of clk.
REQ-021 Data in flight when reset asserts is discarded; no en_out pulse is produced for it.
REQ-022 After rst deasserts, the first en_out occurs 2 edges after the first en_in sampled high.

Structure
REQ-023 The shared package holds the KERNEL→E mapping function (1→0, 3→3, 5→5, 7→6) and the result-width constant N+M+E helper.
REQ-024 The T-input summation is one sub-module, carry_save_adder (parameters: input count T, extension E, width N+M), instantiated once; multipliers stay inline in a generate loop.
REQ-025 Parameter values outside the legal KERNEL set are rejected at elaboration.

Verification (N=4, M=4, KERNEL=3, E=3, d_out 11 bits)
REQ-026 rst=0 mid-stream with en_in=1 -> d_out=0 and en_out=0 immediately; no stale pulse after release.
REQ-027 All data=1, all w=1, one en_in pulse -> 2 cycles later d_out=9, en_out=1 for one cycle.
REQ-028 All data=-8, all w=-8 -> d_out=576 (11'h240).
REQ-029 All data=7, all w=-8 -> d_out=-504 (11'h608).
REQ-030 Three consecutive en_in cycles with sums 9, 576, -504 -> en_out high 3 consecutive cycles with the same values in order; d_out then holds -504 while en_in=0.
REQ-031 KERNEL=1, E=0, data=-3, w=5 -> d_out=8'hF1 (-15) after 2 cycles.
